// File: rtl/hamm_window_ctrl_pkg.sv
// Shared constants, Q15 limits and FSM encoding for the LPC Hamming window stage.
package hamm_window_ctrl_pkg;
  localparam int          L_WINDOW    = 240;
  localparam int          ADDR_W      = 8;
  localparam int          DATA_W      = 16;
  localparam logic [7:0]  SPEECH_BASE = 8'd0;

  localparam logic [15:0] MAX_16    = 16'h7FFF;
  localparam logic [15:0] MIN_16    = 16'h8000;
  localparam logic [31:0] ROUND_Q15 = 32'h0000_4000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_MULT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/hamm_window_ctrl_if.sv
// Memory-read and buffer-write signals between the window controller and its neighbours.
interface hamm_window_ctrl_if;
  import hamm_window_ctrl_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] Speech_Addr;
  logic [DATA_W-1:0] Speech_In;
  logic [ADDR_W-1:0] Hamm_Addr;
  logic [DATA_W-1:0] Hamm_In;
  logic              Out_Write;
  logic [ADDR_W-1:0] Out_Count;
  logic [DATA_W-1:0] Out_Sample;
  logic              done;

  modport master (
    input  start, Speech_In, Hamm_In,
    output Speech_Addr, Hamm_Addr, Out_Write, Out_Count, Out_Sample, done
  );

  modport slave (
    output start, Speech_In, Hamm_In,
    input  Speech_Addr, Hamm_Addr, Out_Write, Out_Count, Out_Sample, done
  );
endinterface

// File: rtl/hamm_window_ctrl_mult_r_q15.sv
// G.729 mult_r: Q15 x Q15 signed multiply with round-to-nearest and 16-bit saturation.
module mult_r_q15
  import hamm_window_ctrl_pkg::*;
(
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic        [15:0] y
);
  logic signed [31:0] prod;
  logic signed [31:0] rnd;
  logic signed [31:0] shr;

  always_comb begin
    prod = a * b;
    rnd  = prod + $signed(ROUND_Q15);
    shr  = rnd >>> 15;
    // Only -32768 * -32768 can exceed the positive limit; the negative clamp is kept for symmetry.
    if (shr > 32'sd32767) begin
      y = MAX_16;
    end else if (shr < -32'sd32768) begin
      y = MIN_16;
    end else begin
      y = shr[15:0];
    end
  end
endmodule

// File: rtl/hamm_window_ctrl.sv
// Reads a 240-sample speech window, applies the Hamming ROM via mult_r and streams results out.
module hamm_window_ctrl
  import hamm_window_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  hamm_window_ctrl_if.master  bus
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] speech_addr_q, speech_addr_d;
  logic [ADDR_W-1:0] hamm_addr_q, hamm_addr_d;
  logic [ADDR_W-1:0] out_count_q, out_count_d;
  logic [DATA_W-1:0] out_sample_q, out_sample_d;
  logic [DATA_W-1:0] prod;
  logic              last_idx;

  mult_r_q15 u_mult (
    .a (bus.Speech_In),
    .b (bus.Hamm_In),
    .y (prod)
  );

  assign last_idx = (idx_q == ADDR_W'(L_WINDOW - 1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    speech_addr_d = speech_addr_q;
    hamm_addr_d   = hamm_addr_q;
    out_count_d   = out_count_q;
    out_sample_d  = out_sample_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          idx_d         = '0;
          speech_addr_d = SPEECH_BASE;
          hamm_addr_d   = '0;
          state_d       = S_FETCH;
        end
      end
      S_FETCH: state_d = S_MULT;
      S_MULT: begin
        out_sample_d = prod;
        out_count_d  = idx_q;
        state_d      = S_WRITE;
      end
      S_WRITE: begin
        if (last_idx) begin
          state_d = S_DONE;
        end else begin
          // Addresses only move on FETCH entry so the memories see a stable read.
          idx_d         = idx_q + 1'b1;
          speech_addr_d = SPEECH_BASE + idx_q + 1'b1;
          hamm_addr_d   = idx_q + 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      speech_addr_q <= '0;
      hamm_addr_q   <= '0;
      out_count_q   <= '0;
      out_sample_q  <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      speech_addr_q <= speech_addr_d;
      hamm_addr_q   <= hamm_addr_d;
      out_count_q   <= out_count_d;
      out_sample_q  <= out_sample_d;
    end
  end

  assign bus.Speech_Addr = speech_addr_q;
  assign bus.Hamm_Addr   = hamm_addr_q;
  assign bus.Out_Count   = out_count_q;
  assign bus.Out_Sample  = out_sample_q;
  assign bus.Out_Write   = (state_q == S_WRITE);
  assign bus.done        = (state_q == S_DONE);
endmodule

// File: tb/tb_hamm_window_ctrl.sv
// Directed-plus-random bench for hamm_window_ctrl against an arithmetic mult_r reference.
module tb_hamm_window_ctrl;
  import hamm_window_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  hamm_window_ctrl_if bus ();

  hamm_window_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] speech_mem [256];
  logic [15:0] hamm_rom   [256];

  // Synchronous-read memories: data reflects the address seen at the previous edge.
  always @(posedge clock) begin
    bus.Speech_In <= speech_mem[bus.Speech_Addr];
    bus.Hamm_In   <= hamm_rom[bus.Hamm_Addr];
  end

  int unsigned edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int unsigned wr_cnt  [$];
  logic [15:0] wr_smp  [$];
  int unsigned wr_edge [$];
  int unsigned done_q  [$];
  int          addr_viol = 0;

  always @(negedge clock) begin
    if (bus.Out_Write === 1'b1) begin
      wr_cnt.push_back(int'(bus.Out_Count));
      wr_smp.push_back(bus.Out_Sample);
      wr_edge.push_back(edge_cnt);
    end
    if (bus.done === 1'b1) done_q.push_back(edge_cnt);
    if (bus.Speech_Addr !== 8'(SPEECH_BASE + bus.Hamm_Addr)) addr_viol++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mult_ref(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint r;
    p = longint'($signed(a)) * longint'($signed(b));
    r = (p + 64'sd16384) >>> 15;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic clear_mon();
    wr_cnt.delete();
    wr_smp.delete();
    wr_edge.delete();
    done_q.delete();
    addr_viol = 0;
  endtask

  task automatic start_frame(output int unsigned n);
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    n = edge_cnt;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      #1;
      if (done_q.size() > 0) break;
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic check_frame(input string tag, input int unsigned n);
    int ord_err = 0;
    int smp_err = 0;
    int tim_err = 0;
    int lim;
    lim = (wr_cnt.size() < L_WINDOW) ? wr_cnt.size() : L_WINDOW;
    for (int k = 0; k < lim; k++) begin
      if (wr_cnt[k] != k) ord_err++;
      if (wr_smp[k] !== mult_ref(speech_mem[8'(SPEECH_BASE + k)], hamm_rom[k])) smp_err++;
      if (wr_edge[k] != n + 3 * k + 2) tim_err++;
    end
    check({tag, "_writes"},    wr_cnt.size(), L_WINDOW);
    check({tag, "_order"},     ord_err, 0);
    check({tag, "_samples"},   smp_err, 0);
    check({tag, "_timing"},    tim_err, 0);
    check({tag, "_done_cnt"},  done_q.size(), 1);
    check({tag, "_done_edge"}, (done_q.size() > 0) ? done_q[0] : 32'hFFFF_FFFF, n + 720);
    check({tag, "_addr"},      addr_viol, 0);
  endtask

  int unsigned n0;
  int          hit;

  initial begin
    bus.start = 1'b0;
    for (int a = 0; a < 256; a++) begin
      speech_mem[a] = 16'($urandom);
      hamm_rom[a]   = 16'($urandom);
    end

    // Reset held with random stimulus.
    reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      bus.start = 1'($urandom);
      speech_mem[$urandom_range(0, 255)] = 16'($urandom);
    end
    #1;
    check("rst_speech_addr", bus.Speech_Addr, 0);
    check("rst_hamm_addr",   bus.Hamm_Addr,   0);
    check("rst_out_write",   bus.Out_Write,   0);
    check("rst_out_count",   bus.Out_Count,   0);
    check("rst_out_sample",  bus.Out_Sample,  0);
    check("rst_done",        bus.done,        0);
    @(negedge clock);
    bus.start = 1'b0;
    reset = 1'b1;
    clear_mon();
    repeat (20) @(negedge clock);
    check("idle_no_write", wr_cnt.size(), 0);
    check("idle_no_done",  done_q.size(), 0);

    // Nominal frame.
    for (int a = 0; a < 256; a++) begin
      speech_mem[a] = 16'h4000;
      hamm_rom[a]   = 16'h7FFF;
    end
    clear_mon();
    start_frame(n0);
    wait_done();
    check_frame("nom", n0);
    check("nom_first_sample", (wr_smp.size() > 0) ? wr_smp[0] : 16'hxxxx, 16'h4000);
    check("nom_last_count", (wr_cnt.size() > 0) ? wr_cnt[wr_cnt.size() - 1] : 32'hFFFF, 239);

    // Rounding and saturation corners, then random pairs.
    for (int a = 0; a < 256; a++) begin
      speech_mem[a] = 16'($urandom);
      hamm_rom[a]   = 16'($urandom);
    end
    speech_mem[SPEECH_BASE + 0] = 16'hFFFD; hamm_rom[0] = 16'h4000;
    speech_mem[SPEECH_BASE + 1] = 16'hFFFF; hamm_rom[1] = 16'h4000;
    speech_mem[SPEECH_BASE + 2] = 16'h8000; hamm_rom[2] = 16'h8000;
    speech_mem[SPEECH_BASE + 3] = 16'h7FFF; hamm_rom[3] = 16'h7FFF;
    clear_mon();
    start_frame(n0);
    wait_done();
    check_frame("rnd", n0);
    check("round_neg3", (wr_smp.size() > 0) ? wr_smp[0] : 16'hxxxx, 16'hFFFF);
    check("round_neg1", (wr_smp.size() > 1) ? wr_smp[1] : 16'hxxxx, 16'h0000);
    check("sat_min_min", (wr_smp.size() > 2) ? wr_smp[2] : 16'hxxxx, 16'h7FFF);
    check("max_max",    (wr_smp.size() > 3) ? wr_smp[3] : 16'hxxxx, 16'h7FFE);

    // Start pulse while busy is ignored.
    for (int a = 0; a < 256; a++) speech_mem[a] = 16'($urandom);
    clear_mon();
    start_frame(n0);
    hit = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      #1;
      if (wr_cnt.size() == 51) begin
        hit = 1;
        break;
      end
    end
    check("busy_reach_50", hit, 1);
    bus.start = 1'b1;
    @(negedge clock);
    #1;
    bus.start = 1'b0;
    wait_done();
    repeat (10) @(negedge clock);
    check_frame("busy", n0);

    clear_mon();
    start_frame(n0);
    wait_done();
    check_frame("after", n0);
    check("after_first_idx", (wr_cnt.size() > 0) ? wr_cnt[0] : 32'hFFFF, 0);

    // Start held high: a new frame begins one idle cycle after done.
    clear_mon();
    @(negedge clock);
    bus.start = 1'b1;
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      #1;
      if (wr_cnt.size() > L_WINDOW) break;
    end
    bus.start = 1'b0;
    check("held_restart_idx", (wr_cnt.size() > L_WINDOW) ? wr_cnt[L_WINDOW] : 32'hFFFF, 0);
    check("held_restart_edge", (wr_cnt.size() > L_WINDOW) ? wr_edge[L_WINDOW] : 32'hFFFF,
          (done_q.size() > 0) ? done_q[0] + 4 : 32'hFFFF_FFFE);
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      #1;
      if (done_q.size() > 1) break;
    end
    check("held_second_done", done_q.size(), 2);
    check("held_total_writes", wr_cnt.size(), 2 * L_WINDOW);

    // Reset during WRITE of sample 100.
    clear_mon();
    start_frame(n0);
    hit = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      #1;
      if (wr_cnt.size() == 101) begin
        hit = 1;
        break;
      end
    end
    check("mid_reach_100", hit, 1);
    reset = 1'b0;
    #1;
    check("mid_write_drop", bus.Out_Write, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    check("mid_no_more_writes", wr_cnt.size(), 101);
    check("mid_no_done", done_q.size(), 0);

    clear_mon();
    start_frame(n0);
    wait_done();
    check_frame("post_rst", n0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hamm_window_ctrl.md
Name: hamm_window_ctrl

Overview:
- Upstream neighbour of the auto-correlation buffer controller.
- On start, reads the 240-sample LPC analysis window from speech memory and multiplies each sample by its Hamming coefficient from the window ROM (Q15 multiply, round and saturate, G.729 mult_r).
- Writes each windowed sample into the auto-correlation buffer through a write-enable / write-address / write-data triple.
- Pulses done once the last sample has been written, so the normalization stage can start reading.

Parameters:
- L_WINDOW, 240, number of samples per analysis window.
- ADDR_W, 8, width of all sample addresses and counts.
- DATA_W, 16, sample and coefficient width (Q15).
- SPEECH_BASE, 0, address of sample 0 in speech memory.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to window a frame; sampled only in IDLE.
- Speech_Addr  out  ADDR_W  read address to speech memory.
- Speech_In  in  DATA_W  speech memory read data; valid one cycle after Speech_Addr is driven.
- Hamm_Addr  out  ADDR_W  read address to Hamming ROM.
- Hamm_In  in  DATA_W  Hamming ROM read data; 1-cycle latency.
- Out_Write  out  1  write strobe to auto-correlation buffer.
- Out_Count  out  ADDR_W  buffer write address (sample index).
- Out_Sample  out  DATA_W  windowed sample.
- done  out  1  one-cycle pulse when the frame is complete.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; index i is cleared to 0.
  - All outputs are 0: Speech_Addr, Hamm_Addr, Out_Write, Out_Count, Out_Sample, done.
- FSM states: IDLE, FETCH, MULT, WRITE, DONE.
  - IDLE: if start=1 at an edge, i <= 0 and go to FETCH. Otherwise stay.
  - FETCH: drive Speech_Addr = SPEECH_BASE+i and Hamm_Addr = i; go to MULT.
  - MULT: Speech_In and Hamm_In are valid. Register prod = mult_r(Speech_In, Hamm_In) into Out_Sample and set Out_Count <= i; go to WRITE.
  - WRITE: Out_Write=1 for exactly this cycle. If i==L_WINDOW-1 go to DONE; else i <= i+1 and go to FETCH.
  - DONE: done=1 for exactly this cycle; go to IDLE.
- Timing: 3 cycles per sample.
  - With start sampled at edge N, sample k is written in the cycle after edge N+3k+2.
  - done is high in the cycle after edge N+720 (L_WINDOW=240).
- Output hold rules:
  - Out_Write and done are 0 in every state other than WRITE and DONE respectively.
  - Out_Sample and Out_Count hold their last values between writes; the buffer ignores them while Out_Write=0.
- Arithmetic, mult_r, all values signed:
  - p = a*b as a 32-bit product; p += 0x00004000; r = p >>> 15 (arithmetic shift).
  - If r > 32767 then r = 32767; if r < -32768 then r = -32768.
  - Only -32768 * -32768 actually saturates, giving 0x7FFF.
- Boundary conditions:
  - start asserted while not in IDLE is ignored; it is not queued.
  - start held high continuously restarts a new frame one cycle after each DONE.
  - i never exceeds L_WINDOW-1; there is no wrap-around within a frame.
  - Reset mid-frame aborts immediately: no further Out_Write pulse and no done pulse. Buffer contents already written are left as is.
  - Addresses change only on FETCH entry, so the memories see stable addresses for the whole read.

Decomposition:
- Shared package: L_WINDOW, Q15 limits (MAX_16=16'h7FFF, MIN_16=16'h8000), ROUND_Q15=32'h00004000, and FSM state encodings.
- One sub-module: mult_r_q15, purely combinational; two 16-bit signed inputs, 16-bit saturated output. It is reusable by other G.729 stages.
- The top level holds the FSM, the index counter and the output registers.

Test Plan:
- Reset values: hold reset=0 for 5 cycles with random inputs -> all outputs 0. Release reset with no start -> FSM stays IDLE and Out_Write never pulses.
- Nominal frame: speech model returns 0x4000 everywhere, ROM returns 0x7FFF everywhere, pulse start -> exactly 240 Out_Write pulses.
  - Out_Count runs 0..239 in order.
  - Every Out_Sample = 0x4000.
  - done is high exactly 720 cycles after the start edge, for one cycle.
- Rounding and saturation per index:
  - (-3, 0x4000) -> 0xFFFF.
  - (-1, 0x4000) -> 0x0000.
  - (0x8000, 0x8000) -> 0x7FFF.
  - (0x7FFF, 0x7FFF) -> 0x7FFE.
  - Results match a C golden mult_r over 240 random pairs.
- Address/latency: memory models that return data only for the address registered on the previous edge -> windowed outputs match golden values; Speech_Addr = SPEECH_BASE+k whenever Hamm_Addr = k.
- Start while busy: pulse start again at sample 50 -> ignored; still exactly 240 writes and one done. A start pulse after done begins a new frame at index 0.
- Mid-frame reset: assert reset during WRITE of sample 100 -> Out_Write drops at once and no done pulse occurs. After release plus start, writes restart at Out_Count 0.
